// File: rtl/mem_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter_if
//   Bundles the requester-side and memory-side signals of the memory bus
//   arbiter.
//   master modport : the arbiter itself (reads requests and memory returns,
//                    drives proc2mem_*, per-requester responses, rsp_*).
//   slave modport  : the surrounding environment (caches plus memory model).
//
//   req_command/addr/data/size : per-requester bus request
//   req_response               : per-requester accept tag (0 = not accepted)
//   rsp_valid/rsp_tag/rsp_data : tagged load-data return, one-hot owner
//   proc2mem_*                 : request forwarded to memory
//   mem2proc_response          : memory accept tag (0 = rejected)
//   mem2proc_tag/mem2proc_data : memory data return (tag 0 = none)
//   err_orphan_tag             : sticky, a return matched no owner
// ---------------------------------------------------------------------------
`ifndef XLEN
`define XLEN 32
`endif

interface mem_bus_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int TAG_W   = 4
);
    logic [NUM_REQ-1:0][1:0]       req_command;
    logic [NUM_REQ-1:0][`XLEN-1:0] req_addr;
    logic [NUM_REQ-1:0][63:0]      req_data;
    logic [NUM_REQ-1:0][1:0]       req_size;
    logic [NUM_REQ-1:0][TAG_W-1:0] req_response;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [TAG_W-1:0]              rsp_tag;
    logic [63:0]                   rsp_data;
    logic [1:0]                    proc2mem_command;
    logic [`XLEN-1:0]              proc2mem_addr;
    logic [63:0]                   proc2mem_data;
    logic [1:0]                    proc2mem_size;
    logic [TAG_W-1:0]              mem2proc_response;
    logic [63:0]                   mem2proc_data;
    logic [TAG_W-1:0]              mem2proc_tag;
    logic                          err_orphan_tag;

    modport master (
        input  req_command, req_addr, req_data, req_size,
        input  mem2proc_response, mem2proc_data, mem2proc_tag,
        output req_response, rsp_valid, rsp_tag, rsp_data,
        output proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size,
        output err_orphan_tag
    );

    modport slave (
        output req_command, req_addr, req_data, req_size,
        output mem2proc_response, mem2proc_data, mem2proc_tag,
        input  req_response, rsp_valid, rsp_tag, rsp_data,
        input  proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size,
        input  err_orphan_tag
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
//   Shares the single processor-to-memory port between NUM_REQ requesters
//   (0 = dcache, 1 = icache). One request is granted per cycle, the memory's
//   accept tag is routed back to the winner, and each accepted load tag is
//   remembered so the tagged data return can be steered to its owner.
//
//   Ports:
//     clock : system clock
//     reset : asynchronous, active-high; clears tag table, counters,
//             arbitration pointer and the orphan flag, and idles all grants
//     bus   : mem_bus_arbiter_if.master (requests, memory port, returns)
//
//   Build option:
//     MEM_ARB_RR_EN defined   -> round-robin arbitration starting at a
//                                pointer that moves past each accepted winner
//     MEM_ARB_RR_EN undefined -> fixed priority, lowest index wins
// ---------------------------------------------------------------------------
`ifndef XLEN
`define XLEN 32
`endif

module mem_bus_arbiter #(
    parameter int NUM_REQ         = 2,
    parameter int TAG_W           = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              clock,
    input  logic              reset,
    mem_bus_arbiter_if.master bus
);
    localparam int OWN_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W    = $clog2(MAX_OUTSTANDING + 1);
    localparam int NUM_TAGS = 1 << TAG_W;

    localparam logic [1:0] BUS_NONE = 2'd0;
    localparam logic [1:0] BUS_LOAD = 2'd1;

    logic [NUM_TAGS-1:0] tag_valid_reg;
    logic [OWN_W-1:0]    tag_owner_reg [NUM_TAGS];
    logic [CNT_W-1:0]    outstanding_reg [NUM_REQ];
    logic                err_orphan_reg;

    logic [NUM_REQ-1:0]  eligible;
    logic [NUM_REQ-1:0]  cnt_inc;
    logic [NUM_REQ-1:0]  cnt_dec;
    logic                grant_valid;
    logic [OWN_W-1:0]    grant_idx;
    logic                accepted;
    logic                grant_load;
    logic                tag_present;
    logic                ret_hit;
    logic                ret_orphan;
    logic [OWN_W-1:0]    ret_owner;

    // A load at its in-flight cap is masked; stores are never masked.
    // Reset gates eligibility so the memory port idles immediately.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign eligible[gi] = !reset
                && (bus.req_command[gi] != BUS_NONE)
                && ((bus.req_command[gi] != BUS_LOAD)
                    || (outstanding_reg[gi] < CNT_W'(MAX_OUTSTANDING)));
            assign cnt_inc[gi] = grant_load && (grant_idx == OWN_W'(gi));
            assign cnt_dec[gi] = ret_hit && (ret_owner == OWN_W'(gi));
        end
    endgenerate

`ifdef MEM_ARB_RR_EN
    logic [OWN_W-1:0] rr_ptr_reg;

    // Search starts at the pointer and wraps around once.
    always_comb begin
        int idx;
        idx         = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr_reg) + k) % NUM_REQ;
            if (!grant_valid && eligible[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = OWN_W'(idx);
            end
        end
    end

    // Only an accepted grant moves the pointer, so a rejected winner is
    // re-selected next cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr_reg <= '0;
        end else if (accepted) begin
            rr_ptr_reg <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
        end
    end
`else
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_valid && eligible[k]) begin
                grant_valid = 1'b1;
                grant_idx   = OWN_W'(k);
            end
        end
    end
`endif

    // Winner's request drives memory; the accept tag goes only to the winner.
    always_comb begin
        bus.proc2mem_command = BUS_NONE;
        bus.proc2mem_addr    = '0;
        bus.proc2mem_data    = '0;
        bus.proc2mem_size    = '0;
        bus.req_response     = '0;
        if (grant_valid) begin
            bus.proc2mem_command        = bus.req_command[grant_idx];
            bus.proc2mem_addr           = bus.req_addr[grant_idx];
            bus.proc2mem_data           = bus.req_data[grant_idx];
            bus.proc2mem_size           = bus.req_size[grant_idx];
            bus.req_response[grant_idx] = bus.mem2proc_response;
        end
    end

    assign accepted    = grant_valid && (bus.mem2proc_response != '0);
    assign grant_load  = accepted && (bus.req_command[grant_idx] == BUS_LOAD);

    assign tag_present = (bus.mem2proc_tag != '0);
    assign ret_hit     = !reset && tag_present && tag_valid_reg[bus.mem2proc_tag];
    assign ret_orphan  = tag_present && !tag_valid_reg[bus.mem2proc_tag];
    assign ret_owner   = tag_owner_reg[bus.mem2proc_tag];

    always_comb begin
        bus.rsp_valid = '0;
        if (ret_hit) begin
            bus.rsp_valid[ret_owner] = 1'b1;
        end
    end

    assign bus.rsp_tag        = bus.mem2proc_tag;
    assign bus.rsp_data       = bus.mem2proc_data;
    assign bus.err_orphan_tag = err_orphan_reg;

    // Free before allocate: when the same tag is returned and re-issued in
    // one cycle, the later write leaves the entry valid with the new owner.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tag_valid_reg  <= '0;
            err_orphan_reg <= 1'b0;
            for (int t = 0; t < NUM_TAGS; t++) begin
                tag_owner_reg[t] <= '0;
            end
        end else begin
            if (ret_hit) begin
                tag_valid_reg[bus.mem2proc_tag] <= 1'b0;
            end
            if (grant_load) begin
                tag_valid_reg[bus.mem2proc_response] <= 1'b1;
                tag_owner_reg[bus.mem2proc_response] <= grant_idx;
            end
            if (ret_orphan) begin
                err_orphan_reg <= 1'b1;
            end
        end
    end

    // Increment and decrement in the same cycle cancel; the eligibility mask
    // keeps the counter from ever exceeding MAX_OUTSTANDING.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                outstanding_reg[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REQ; r++) begin
                outstanding_reg[r] <= outstanding_reg[r]
                                    + CNT_W'(cnt_inc[r]) - CNT_W'(cnt_dec[r]);
            end
        end
    end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single processor-to-memory port (proc2mem_* / mem2proc_*) between NUM_REQ requesters: index 0 = dcache, index 1 = icache.
- Selects one request per cycle and returns the memory's accept tag to the winner.
- Records which requester owns each outstanding load tag, and routes tagged data returns back to that owner.
- Sits between the caches and the `mem` model, inside `processor`.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- TAG_W, 4, width of memory response/tag; tag 0 means "none".
- MAX_OUTSTANDING, 4, maximum in-flight loads per requester; a requester at the cap is masked from arbitration.

Ports:
- clock  in  1  system clock.
- reset  in  1  system reset.
- req_command  in  NUM_REQ x 2  per-requester BUS_NONE / BUS_LOAD / BUS_STORE.
- req_addr  in  NUM_REQ x `XLEN  per-requester address.
- req_data  in  NUM_REQ x 64  per-requester store data.
- req_size  in  NUM_REQ x 2  per-requester MEM_SIZE.
- req_response  out  NUM_REQ x TAG_W  mem2proc_response routed to the granted requester; 0 to all others.
- rsp_valid  out  NUM_REQ  one-hot; data return for that requester this cycle.
- rsp_tag  out  TAG_W  broadcast of mem2proc_tag.
- rsp_data  out  64  broadcast of mem2proc_data.
- proc2mem_command  out  2  command to memory.
- proc2mem_addr  out  `XLEN  address to memory.
- proc2mem_data  out  64  store data to memory.
- proc2mem_size  out  2  access size to memory.
- mem2proc_response  in  TAG_W  accept tag; 0 = rejected.
- mem2proc_data  in  64  returned load data.
- mem2proc_tag  in  TAG_W  tag of returned data; 0 = none.
- err_orphan_tag  out  1  sticky: a data return arrived for a tag with no valid owner.

Behaviour:
- Clock and reset: one clock, `clock`. `reset` is asynchronous, active-high.
- Reset clears:
  - tag table (2^TAG_W entries of {valid, owner}),
  - per-requester outstanding counters,
  - round-robin pointer (to 0),
  - err_orphan_tag.
- Outputs with no requests active: proc2mem_command = BUS_NONE, address/data/size = 0, req_response = 0, rsp_valid = 0.
- Eligibility: requester i is eligible when req_command[i] != BUS_NONE, and for a LOAD, outstanding[i] < MAX_OUTSTANDING. A STORE is never masked.
- Grant is combinational, same cycle. The winner's command/addr/data/size drive proc2mem_*.
- mem2proc_response is routed combinationally to req_response[winner] in the same cycle. Zero latency: the memory accepts on the current posedge.
- Accepted = winner exists and mem2proc_response != 0. Rejected = response 0. On rejection:
  - no state change;
  - the requester must hold its request;
  - the pointer is not advanced, so the same winner is re-selected next cycle if still requesting.
- On an accepted LOAD (posedge):
  - table[mem2proc_response] <= {1, winner};
  - outstanding[winner]++.
- An accepted STORE allocates no entry and changes no counter.
- Data return, when mem2proc_tag != 0:
  - If table[tag].valid: rsp_valid[owner] = 1 combinationally; at posedge clear the entry and decrement outstanding[owner].
  - If the entry is invalid: no rsp_valid, entry unchanged; err_orphan_tag <= 1 (sticky until reset).
- Same cycle, same tag returned and newly allocated: the free applies first, then the allocate. The entry ends valid with the new owner, and both counters update.
- Same requester, one return and one accept in the same cycle: net counter change is 0.
- Counters never wrap. Saturation is prevented by the eligibility mask.
- Reset mid-transaction discards all table state. Returns that arrive after reset with stale tags raise err_orphan_tag.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration.
  - Search begins at the pointer.
  - On an accepted grant, pointer <= (winner + 1) mod NUM_REQ.
- Undefined: fixed priority, lowest index wins (dcache over icache). The pointer register is not instantiated.

Test Plan:
- Reset, then dcache LOAD 0x100 alone, memory responds tag 3 -> req_response[0] = 3; table[3] = {1, 0}; 10 cycles later tag 3 with data 0xDEADBEEF_00000001 -> rsp_valid = 2'b01, rsp_data matches, outstanding[0] back to 0.
- Both requesters issue LOADs every cycle, memory always accepts:
  - with MEM_ARB_RR_EN, grants alternate 0,1,0,1;
  - without it, requester 0 wins every cycle and icache req_response stays 0.
- Memory returns response 0 for 3 cycles -> same winner held, no table writes, pointer unchanged; accepted on cycle 4.
- icache issues 4 LOADs with no returns (MAX_OUTSTANDING = 4) -> 5th LOAD masked and req_response[1] = 0; dcache STORE still granted; after one return, icache is granted again.
- mem2proc_tag = 7 with no entry for tag 7 -> no rsp_valid, err_orphan_tag rises and stays 1 until reset; tag 5 freed and reallocated in the same cycle -> entry valid with the new owner.
- Assert reset asynchronously mid-burst, between clock edges -> all outputs go idle immediately, table cleared.
